// File: rtl/rec_packer.sv
// -----------------------------------------------------------------------------
// rec_packer
//   Packs 2-bit records {flag, data} into 32-bit words of up to 16 records.
//   A word closes on its 16th record or on a record marked in_last, and the
//   closed word is queued in a DEPTH-entry output FIFO.
//
// Parameters
//   DEPTH      output FIFO entries (power of two, 2..16)
//
// Ports
//   clk        single clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream record valid
//   in_ready   record accepted this cycle (FIFO not full)
//   in_rec     record {flag, data}, flag at bit 1
//   in_last    record closes the current word early
//   out_valid  packed word available (FIFO not empty)
//   out_ready  downstream takes the word this cycle
//   out_word   packed records, k-th record at [2k+1:2k], unfilled bits 0
//   out_cnt    records in out_word, 1..16
//   out_last   word was closed by in_last
//   out_par    XOR of out_word (only with REC_PACKER_PARITY_EN defined)
//
// Build option
//   REC_PACKER_PARITY_EN  adds the out_par port and its stored parity bit.
// -----------------------------------------------------------------------------
module rec_packer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_rec,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [4:0]  out_cnt,
  output logic        out_last
`ifdef REC_PACKER_PARITY_EN
  ,
  output logic        out_par
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FILL  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Accumulator
  // ---------------------------------------------------------------------------
  state_t      state;
  logic [3:0]  k;
  logic [31:0] acc;
  logic [31:0] next_word;
  logic        accept;
  logic        close;
  logic        push;
  logic        pop;

  assign accept = in_valid && in_ready;
  assign close  = accept && (in_last || (k == 4'd15));
  assign push   = close;

  // Word as it looks after inserting the current record at slot k.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    next_word = (state == EMPTY) ? '0 : acc;
    // NOTE: blocking '=' in combinational logic, non-blocking '<=' for all clocked state below.
    next_word[{k, 1'b0} +: 2] = in_rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      k     <= '0;
      acc   <= '0;
    end else if (accept) begin
      if (close) begin
        state <= EMPTY;
        k     <= '0;
        acc   <= '0;
      end else begin
        state <= FILL;
        k     <= k + 4'd1;
        acc   <= next_word;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]   mem_word [DEPTH];
  logic [4:0]    mem_cnt  [DEPTH];
  logic          mem_last [DEPTH];
`ifdef REC_PACKER_PARITY_EN
  logic          mem_par  [DEPTH];
`endif
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // NOTE: storage is deliberately not reset; the outputs are forced to zero while the FIFO is empty, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_word[wr_ptr] <= next_word;
      mem_cnt[wr_ptr]  <= {1'b0, k} + 5'd1;
      mem_last[wr_ptr] <= in_last;
`ifdef REC_PACKER_PARITY_EN
      mem_par[wr_ptr]  <= ^next_word;
`endif
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flow control comes only from the registered count.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  assign out_word  = out_valid ? mem_word[rd_ptr] : '0;
  assign out_cnt   = out_valid ? mem_cnt[rd_ptr]  : '0;
  assign out_last  = out_valid ? mem_last[rd_ptr] : 1'b0;
`ifdef REC_PACKER_PARITY_EN
  assign out_par   = out_valid ? mem_par[rd_ptr]  : 1'b0;
`endif

endmodule

// File: tb/tb_rec_packer.sv
// -----------------------------------------------------------------------------
// tb_rec_packer
//   Directed bench for rec_packer (DEPTH=4). Expected words are built by a
//   small record-packing model and queued when the closing beat is accepted;
//   a negedge monitor pops and compares every word the DUT hands downstream.
// -----------------------------------------------------------------------------
module tb_rec_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_rec;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [4:0]  out_cnt;
  logic        out_last;
`ifdef REC_PACKER_PARITY_EN
  logic        out_par;
`endif

  always #5 clk = ~clk;

  rec_packer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rec    (in_rec),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_cnt   (out_cnt),
    .out_last  (out_last)
`ifdef REC_PACKER_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  typedef struct {
    logic [31:0] word;
    logic [4:0]  cnt;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          tests  = 0;
  int          fails  = 0;
  int          pushed = 0;
  int          popped = 0;
  logic [31:0] m_word = '0;
  int          m_k    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: a word leaves the DUT on every out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", {31'b0, out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_word", out_word, e.word);
        check("sb_cnt",  {27'b0, out_cnt}, {27'b0, e.cnt});
        check("sb_last", {31'b0, out_last}, {31'b0, e.last});
`ifdef REC_PACKER_PARITY_EN
        check("sb_par",  {31'b0, out_par}, {31'b0, ^e.word});
`endif
        popped++;
      end
    end
  end

  // Drive one record and hold it until accepted; returns just after the
  // accepting edge with the inputs still driven (back-to-back friendly).
  task automatic send(input logic [1:0] rec, input logic last);
    int n;
    in_valid = 1'b1;
    in_rec   = rec;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      m_word[2*m_k +: 2] = rec;
      m_k++;
      if (m_k == 16 || last) begin
        sb.push_back('{word: m_word, cnt: 5'(m_k), last: last});
        pushed++;
        m_word = '0;
        m_k    = 0;
      end
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_rec   = 2'b00;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] xw;

    rst_n     = 1'b0;
    out_ready = 1'b0;
    idle();

    // Reset state
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_word",  out_word, 32'd0);
    check("rst_out_cnt",   {27'b0, out_cnt}, 32'd0);
    check("rst_out_last",  {31'b0, out_last}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready}, 32'd1);

    // Full word: first beat taken on the first edge after reset release
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(2'b01, 1'b0);
      if (i == 14) check("full_not_yet", {31'b0, out_valid}, 32'd0);
    end
    check("full_valid", {31'b0, out_valid}, 32'd1);
    check("full_word",  out_word, 32'h5555_5555);
    check("full_cnt",   {27'b0, out_cnt}, 32'd16);
    check("full_last",  {31'b0, out_last}, 32'd0);
    idle();
    @(posedge clk); #1;

    // Early close
    send(2'b10, 1'b0);
    send(2'b11, 1'b0);
    send(2'b01, 1'b1);
    idle();
    check("early_word", out_word, 32'h0000_001E);
    check("early_cnt",  {27'b0, out_cnt}, 32'd3);
    check("early_last", {31'b0, out_last}, 32'd1);
`ifdef REC_PACKER_PARITY_EN
    check("par_1e", {31'b0, out_par}, 32'd0);
`endif
    @(posedge clk); #1;

    // Close on the first record; X flag travels through untouched
    send(2'b01, 1'b1);
    idle();
    check("single_word", out_word, 32'h0000_0001);
    check("single_cnt",  {27'b0, out_cnt}, 32'd1);
`ifdef REC_PACKER_PARITY_EN
    check("par_01", {31'b0, out_par}, 32'd1);
`endif
    @(posedge clk); #1;
    send(2'bx1, 1'b1);
    idle();
    xw = '0;
    xw[1:0] = 2'bx1;
    check("xflag_word", out_word, xw);
    drain();

    // Backpressure: four words fill the FIFO, then in_ready drops
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 4) begin
        idle();
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        held = out_word;
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_word",  out_word, held);
        check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
      end
      send(2'($urandom_range(0, 3)), 1'b1);
    end
    idle();
    drain();
    check("bp_none_lost", popped, pushed);

    // Simultaneous push/pop with two words queued, across pointer wrap
    out_ready = 1'b0;
    send(2'b10, 1'b1);
    send(2'b01, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(2'(i % 4), 1'b1);
      check("pp_count", 32'(dut.count), 32'd2);
    end
    idle();
    drain();

    // Reset mid-word with a queued word
    out_ready = 1'b0;
    send(2'b01, 1'b1);
    for (int i = 0; i < 7; i++) send(2'b10, 1'b0);
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mrst_out_word",  out_word, 32'd0);
    check("mrst_in_ready",  {31'b0, in_ready}, 32'd1);
    sb.delete();
    pushed = popped;
    m_word = '0;
    m_k    = 0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(2'b11, 1'b0);
    idle();
    check("mrst_fresh_cnt",  {27'b0, out_cnt}, 32'd16);
    check("mrst_fresh_word", out_word, 32'hFFFF_FFFF);
    drain();
    check("final_balance", popped, pushed);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
